// File: rtl/spi_ctrl_module.sv
// spi_ctrl_module: single-channel 8-bit full-duplex SPI master.
// Configured by one 32-bit word holding the C1 / C2 / Status / Baud bytes of an SPIx-style register set.
module spi_ctrl_module #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              MISO,
  input  logic [31:0]       data_config,
  input  logic              trans_en,
  output logic              interupt_request,
  output logic [DATA_W-1:0] o_data,
  output logic              MOSI,
  output logic              SCK,
  output logic              SS
);

  localparam int unsigned HALF_W    = 11;
  localparam int unsigned EDGE_W    = 5;
  localparam int unsigned NUM_EDGES = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t              state;
  logic [HALF_W-1:0]   hcnt;
  logic [HALF_W-1:0]   half_q;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;
  logic                cpol_q;
  logic                cpha_q;
  logic                lsbfe_q;
  logic                rx_full;

  // Live configuration fields.
  logic       cfg_spie, cfg_spe, cfg_sptie, cfg_mstr;
  logic       cfg_cpol, cfg_cpha, cfg_ssoe, cfg_lsbfe, cfg_modfen;
  logic [2:0] cfg_sppr;
  logic [3:0] cfg_spr;
  logic       unused_cfg;

  assign cfg_spie   = data_config[31];
  assign cfg_spe    = data_config[30];
  assign cfg_sptie  = data_config[29];
  assign cfg_mstr   = data_config[28];
  assign cfg_cpol   = data_config[27];
  assign cfg_cpha   = data_config[26];
  assign cfg_ssoe   = data_config[25];
  assign cfg_lsbfe  = data_config[24];
  assign cfg_modfen = data_config[20];
  assign cfg_sppr   = data_config[6:4];
  assign cfg_spr    = data_config[3:0];
  assign unused_cfg = ^{data_config[23:21], data_config[19:16], data_config[15:7]};

  // Half-period length in clk cycles: (SPPR+1) * 2^SPR, SPR saturated at 7.
  logic [2:0]        spr_sat;
  logic [HALF_W-1:0] half_len;
  logic [HALF_W-1:0] half_m1;

  always_comb begin
    spr_sat  = (cfg_spr > 4'd7) ? 3'd7 : cfg_spr[2:0];
    half_len = (HALF_W'(cfg_sppr) + HALF_W'(1)) << spr_sat;
    half_m1  = half_len - HALF_W'(1);
  end

  // First bit and remaining shift data for a frame starting now.
  logic              first_bit;
  logic [DATA_W-1:0] first_shift;

  always_comb begin
    first_bit   = cfg_lsbfe ? i_data[0] : i_data[DATA_W-1];
    first_shift = cfg_lsbfe ? (i_data >> 1) : (i_data << 1);
  end

  // Per-edge decode: which edge is due, and whether it drives MOSI or samples MISO.
  logic [EDGE_W-1:0] edge_idx;
  logic              do_edge;
  logic              leading;
  logic              do_drive;
  logic              do_sample;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_next;

  always_comb begin
    edge_idx   = (state == LEAD) ? '0 : edge_cnt;
    do_edge    = (hcnt == '0) &&
                 ((state == LEAD) || ((state == SHIFT) && (edge_cnt != EDGE_W'(NUM_EDGES))));
    leading    = ~edge_idx[0];
    do_drive   = cpha_q ? leading : (~leading && (edge_idx != EDGE_W'(NUM_EDGES - 1)));
    do_sample  = cpha_q ? ~leading : leading;
    tx_bit     = lsbfe_q ? tx_sh[0] : tx_sh[DATA_W-1];
    tx_shifted = lsbfe_q ? (tx_sh >> 1) : (tx_sh << 1);
    rx_next    = lsbfe_q ? {MISO, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], MISO};
  end

  // Transfer FSM with registered SCK/MOSI/SS/o_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      half_q   <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsbfe_q  <= 1'b0;
      rx_full  <= 1'b0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      SS       <= 1'b1;
      o_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          SCK <= cfg_cpol;
          SS  <= 1'b1;
          if (trans_en && cfg_spe && cfg_mstr) begin
            state    <= LEAD;
            hcnt     <= half_m1;
            half_q   <= half_m1;
            edge_cnt <= '0;
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            lsbfe_q  <= cfg_lsbfe;
            rx_full  <= 1'b0;
            rx_sh    <= '0;
            SS       <= ~(cfg_ssoe & cfg_modfen);
            if (!cfg_cpha) begin
              MOSI  <= first_bit;
              tx_sh <= first_shift;
            end else begin
              tx_sh <= i_data;
            end
          end
        end
        default: begin
          if (!cfg_spe) begin
            // Abort: drop back to idle without touching received data.
            state <= IDLE;
            SS    <= 1'b1;
            SCK   <= cfg_cpol;
          end else if (hcnt != '0) begin
            hcnt <= hcnt - HALF_W'(1);
          end else begin
            hcnt <= half_q;
            if (do_edge) begin
              SCK      <= leading ? ~cpol_q : cpol_q;
              edge_cnt <= edge_idx + EDGE_W'(1);
              if (do_drive) begin
                MOSI  <= tx_bit;
                tx_sh <= tx_shifted;
              end
              if (do_sample) begin
                rx_sh <= rx_next;
              end
              if (state == LEAD) begin
                state <= SHIFT;
              end
            end else if (state == SHIFT) begin
              state <= TRAIL;
            end else begin
              state   <= IDLE;
              SS      <= 1'b1;
              o_data  <= rx_sh;
              rx_full <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Interrupt from receive-full and transmit-empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interupt_request <= 1'b0;
    end else begin
      interupt_request <= (cfg_spie & rx_full) | (cfg_sptie & (state == IDLE));
    end
  end

endmodule

// File: tb/tb_spi_ctrl_module.sv
// tb_spi_ctrl_module: scoreboard bench for the SPI master, loopback plus a small slave model.
`timescale 1ns/1ps
module tb_spi_ctrl_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        miso;
  logic [31:0] data_config = 32'h0;
  logic        trans_en = 1'b0;
  logic        irq;
  logic [7:0]  o_data;
  logic        mosi;
  logic        sck;
  logic        ss;

  spi_ctrl_module dut (
    .clk              (clk),
    .rst              (rst),
    .i_data           (i_data),
    .MISO             (miso),
    .data_config      (data_config),
    .trans_en         (trans_en),
    .interupt_request (irq),
    .o_data           (o_data),
    .MOSI             (mosi),
    .SCK              (sck),
    .SS               (ss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] mosi;
    int         ss_low;
    int         toggles;
    int         span;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Bench-side view of the active mode, used by the monitor to pick sampling edges.
  logic t_cpol = 1'b0, t_cpha = 1'b0, t_lsb = 1'b0;
  logic mon_clr = 1'b0;

  // Slave model: shifts slave_byte out MSB first for CPOL=1/CPHA=0.
  logic       slave_mode = 1'b0;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_byte = 8'hC3;
  int         sidx = -1;

  always @(negedge ss) if (slave_mode) begin slave_bit = slave_byte[7]; sidx = 6; end
  always @(posedge sck) if (slave_mode && !ss && sidx >= 0) begin slave_bit = slave_byte[sidx]; sidx--; end
  assign miso = slave_mode ? slave_bit : mosi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: measures each frame and compares against the scoreboard on irq rising.
  logic       prev_irq = 1'b0, prev_sck = 1'b0, lead_edge;
  int         cyc = 0, ss_low = 0, toggles = 0, first_t = 0, last_t = 0;
  logic [7:0] cap = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (rst || mon_clr) begin
      ss_low  = 0;
      toggles = 0;
    end else begin
      if (irq && !prev_irq) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got o_data %0h expected no frame", o_data);
        end else begin
          e = sb.pop_front();
          chk("o_data", 32'(o_data), 32'(e.data));
          chk("mosi_bits", 32'(cap), 32'(e.mosi));
          chk("ss_low_cycles", ss_low, e.ss_low);
          chk("sck_toggles", toggles, e.toggles);
          chk("sck_span", last_t - first_t, e.span);
        end
        ss_low  = 0;
        toggles = 0;
      end
      if (!ss) ss_low++;
      if (sck != prev_sck) begin
        if (toggles == 0) first_t = cyc;
        last_t = cyc;
        toggles++;
        lead_edge = (sck != t_cpol);
        if ((!t_cpha && lead_edge) || (t_cpha && !lead_edge))
          cap = t_lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
      end
    end
    prev_sck = sck;
    prev_irq = irq;
  end

  task automatic setup(input logic [31:0] cfg, input logic slave);
    @(posedge clk); #2;
    data_config = cfg;
    t_cpol      = cfg[27];
    t_cpha      = cfg[26];
    t_lsb       = cfg[24];
    slave_mode  = slave;
    repeat (3) @(posedge clk);
    #2 mon_clr = 1'b1;
    @(posedge clk); #2 mon_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] data, input logic [7:0] mo, input int ssl, input int span);
    exp_t x;
    x.data = data; x.mosi = mo; x.ss_low = ssl; x.toggles = 16; x.span = span;
    sb.push_back(x);
  endtask

  task automatic pulse(input logic [7:0] d);
    i_data = d;
    trans_en = 1'b1;
    @(posedge clk); #2 trans_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d frames outstanding expected 0", name, sb.size());
      sb.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    // Loopback, CPOL=0 CPHA=1, D=8.
    setup(32'hD6108011, 1'b0);
    push(8'hA5, 8'hA5, 72, 60);
    pulse(8'hA5);
    wait_done("loop_a5", 200);

    // CPOL=1 CPHA=0, slave returns 0xC3.
    setup(32'hDA108011, 1'b1);
    chk("sck_idle_cpol1", 32'(sck), 32'd1);
    push(8'hC3, 8'h3C, 72, 60);
    pulse(8'h3C);
    wait_done("slave_c3", 200);

    // LSB first, only the first bit slot high.
    setup(32'hD7108011, 1'b0);
    push(8'h01, 8'h01, 72, 60);
    pulse(8'h01);
    wait_done("lsbfe", 200);

    // Fastest baud: D=2.
    setup(32'hD6108000, 1'b0);
    push(8'h5A, 8'h5A, 18, 15);
    pulse(8'h5A);
    wait_done("baud_min", 100);

    // Slowest baud: D=2048.
    setup(32'hD6108077, 1'b0);
    push(8'h96, 8'h96, 18432, 15360);
    pulse(8'h96);
    wait_done("baud_max", 20000);

    // trans_en held high: exactly two back-to-back frames.
    setup(32'hD6108011, 1'b0);
    push(8'h81, 8'h81, 72, 60);
    push(8'h81, 8'h81, 72, 60);
    i_data = 8'h81;
    trans_en = 1'b1;
    repeat (80) @(posedge clk);
    #2 trans_en = 1'b0;
    wait_done("held", 300);

    // SSOE=0: SS stays high, frame still completes.
    setup(32'hD4108011, 1'b0);
    push(8'h42, 8'h42, 0, 60);
    pulse(8'h42);
    wait_done("ssoe0", 200);

    // Reset during bit 4 of a frame.
    setup(32'hD6108011, 1'b0);
    chk("o_data_before_rst", 32'(o_data), 32'h42);
    pulse(8'h77);
    repeat (36) @(posedge clk);
    #2;
    chk("ss_mid_frame", 32'(ss), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_ss", 32'(ss), 32'd1);
    chk("midrst_sck", 32'(sck), 32'd0);
    chk("midrst_o_data", 32'(o_data), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // MSTR=0: trans_en ignored.
    setup(32'hC6108011, 1'b0);
    pulse(8'h55);
    repeat (100) @(posedge clk);
    #2;
    chk("mstr0_toggles", toggles, 0);
    chk("mstr0_ss", 32'(ss), 32'd1);
    chk("mstr0_irq", 32'(irq), 32'd0);
    chk("mstr0_sck", 32'(sck), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
